// File: rtl/transfer_reg_file_pkg.sv
// transfer_reg_file_pkg
//   Shared datapath constants for the general-purpose register bank:
//   default word width and depth, the reset/clear word value, and the
//   helper that sizes the address ports.
package transfer_reg_file_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 8;

   // Every bit of a reset or cleared word takes this value.
   localparam logic CLEAR_BIT = 1'b0;

   // Address width for a given depth. Depth is always at least 2, so this
   // matches $clog2 while never returning a zero-width address.
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/transfer_or_nbit.sv
// transfer_or_nbit
//   WIDTH-bit OR transfer gate. This is the load-or-hold selector in front
//   of each register word.
//   Ports:
//     select    : 1 = pass new_data, 0 = pass hold_data
//     new_data  : candidate write data
//     hold_data : current register contents
//     out       : next-state value for the register
module transfer_or_nbit #(
   parameter int WIDTH = 16
) (
   input  logic             select,
   input  logic [WIDTH-1:0] new_data,
   input  logic [WIDTH-1:0] hold_data,
   output logic [WIDTH-1:0] out
);

   // Two AND-gated paths merged by an OR. The select lines are
   // complementary, so exactly one path is open at a time.
   assign out = ({WIDTH{select}} & new_data) | ({WIDTH{~select}} & hold_data);

endmodule

// File: rtl/transfer_reg_file.sv
// transfer_reg_file
//   General-purpose register bank between the ALU result bus and the
//   operand-select stage. It has one write port and two combinational read
//   ports, an optional write-through bypass, a synchronous clear-all and a
//   registered write acknowledge.
//   Ports:
//     clk              : clock, rising edge
//     rst              : synchronous active-high reset (beats clr, which beats we)
//     clr              : synchronous clear of all words; drops a same-cycle write
//     we/waddr/wdata   : write port; an out-of-range address is ignored
//     raddr_a/rdata_a  : read port A, combinational
//     raddr_b/rdata_b  : read port B, combinational
//     wr_ack           : high for one cycle after each effective write
module transfer_reg_file
   import transfer_reg_file_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0,
   localparam int AW     = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   output logic             wr_ack
);

   localparam logic [WIDTH-1:0] CLEAR_WORD = {WIDTH{CLEAR_BIT}};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] load;
   logic             wr_eff;
   logic             wr_ack_q;
   logic             wr_ack_d;
   logic [WIDTH-1:0] rdata_v [2];

   // Per-word load decode and transfer gate. An out-of-range waddr matches
   // no word index, so such a write loads nothing.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [AW-1:0] IDX   = AW'(i);
      localparam logic          HARD0 = (ZERO_R0 != 0) && (i == 0);

      assign load[i] = we & (waddr == IDX) & ~clr & ~rst & ~HARD0;

      transfer_or_nbit #(
         .WIDTH (WIDTH)
      ) u_gate (
         .select    (load[i]),
         .new_data  (wdata),
         .hold_data (mem_q[i]),
         .out       (mem_d[i])
      );
   end

   // A write is effective exactly when some word loads. This one signal
   // drives both the acknowledge and the bypass.
   assign wr_eff   = |load;
   assign wr_ack_d = wr_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= CLEAR_WORD;
         wr_ack_q <= 1'b0;
      end else if (clr) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= CLEAR_WORD;
         wr_ack_q <= 1'b0;
      end else begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
         wr_ack_q <= wr_ack_d;
      end
   end

   // Read ports: p=0 is port A, p=1 is port B.
   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [AW-1:0]    addr_p;
      logic [WIDTH-1:0] stored;

      assign addr_p = (p == 0) ? raddr_a : raddr_b;

      // An out-of-range address matches no word and reads as 0. When
      // ZERO_R0 is set, word 0 is hard-wired to read 0.
      always_comb begin
         stored = CLEAR_WORD;
         for (int i = 0; i < DEPTH; i++) begin
            if ((addr_p == AW'(i)) && !((ZERO_R0 != 0) && (i == 0))) stored = mem_q[i];
         end
      end

      if (BYPASS != 0) begin : g_byp
         // wr_eff is already low during rst/clr, so those cycles read the
         // pre-clear contents.
         assign rdata_v[p] = (wr_eff && (addr_p == waddr)) ? wdata : stored;
      end else begin : g_nobyp
         assign rdata_v[p] = stored;
      end
   end

   assign rdata_a = rdata_v[0];
   assign rdata_b = rdata_v[1];
   assign wr_ack  = wr_ack_q;

endmodule

// File: doc/transfer_reg_file.md
# transfer_reg_file

Parametrised register file for the datapath. Each word is a load-or-hold storage cell built from a WIDTH-generalised OR transfer gate feeding a register. It has one write port, two independent combinational read ports, an optional write-through bypass, a synchronous clear-all, and a registered write acknowledge. It sits between the ALU result bus and the operand-select stage, and serves as the general-purpose register bank.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of words (≥2; need not be a power of two)
- BYPASS, 1, 1: a write is visible on a read port in the same cycle; 0: visible from the next cycle
- ZERO_R0, 0, 1: word 0 reads constant 0 and ignores writes
- AW (localparam), $clog2(DEPTH), address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear of all words
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read address, port A
- rdata_a  out  WIDTH  read data, port A (combinational)
- raddr_b  in  AW  read address, port B
- rdata_b  out  WIDTH  read data, port B (combinational)
- wr_ack  out  1  registered pulse: the previous cycle's write committed

## Operation
- Per word i:
  - load = we & (waddr==i) & ~clr & ~(ZERO_R0 & i==0).
  - Next value = transfer gate output: wdata when load=1, current value when load=0.
- Priority per edge is rst > clr > we.
  - rst: all words 0, wr_ack 0.
  - clr: all words 0, wr_ack 0, and any same-cycle write is dropped.
- Write address out of range (waddr ≥ DEPTH): the write is ignored, no word changes, wr_ack 0.
- ZERO_R0=1 and waddr==0: the write is ignored and wr_ack is 0.
- Read ports:
  - rdata_x = word[raddr_x].
  - An out-of-range raddr returns 0.
  - With ZERO_R0=1, address 0 returns 0.
- Bypass (BYPASS=1): if a write is effective this cycle (load would assert for some word) and raddr_x==waddr, then rdata_x = wdata. This applies to both ports independently, including when both ports read the same address.
- Bypass never applies when clr=1 or rst=1. During those cycles, reads return the stored (pre-clear) value.
- wr_ack is registered: wr_ack(t+1) = effective write at t, i.e. rst=0 & clr=0 & we & in-range & not a ZERO_R0 drop.

## Timing
- Write latency: data is stored at edge t. It is readable from cycle t+1 with BYPASS=0, or in cycle t itself with BYPASS=1.
- Read latency: 0 cycles. The read path is purely combinational from raddr_x to rdata_x.
- wr_ack goes high exactly 1 cycle after an effective write and lasts one cycle per write. Back-to-back writes keep it high continuously.
- Reset values: all words 0, wr_ack 0. rdata_a and rdata_b therefore read 0 after reset for any address.
- Reset or clr asserted in the same cycle as a write: the write is lost and wr_ack is 0 in the following cycle.
- Holding the write address constant with we=0 leaves the word unchanged indefinitely. There is no refresh and no side effect.

## Structure
- Shared package (datapath constants): default WIDTH=16, default DEPTH=8, and reset/clear word value 0.
- Sub-module transfer_or_nbit: combinational WIDTH-parameterised OR transfer gate (select, new_data, hold_data, out). One instance per word.
  - The register and the priority logic stay in transfer_reg_file.
  - Read multiplexing and the bypass compare are generate-based in the top module.
- Expected size: 150–250 lines of RTL.

## Test plan
- Reset: assert rst for 2 cycles, then read all 8 addresses on both ports → 0x0000 everywhere, wr_ack=0.
- Basic write/read (BYPASS=0): write 0xBEEF to address 3 → rdata_a(raddr_a=3) is 0xBEEF from cycle t+1 (old value at t), and wr_ack=1 at t+1 only.
- Bypass (BYPASS=1): write 0x1234 to address 5 with raddr_a=raddr_b=5 in the same cycle → both ports show 0x1234 at t; a read of address 4 is unaffected.
- Clear vs write: words 1..7 hold 0x00AA; assert clr and we (waddr=2, wdata=0x5555) together → next cycle all words are 0, wr_ack=0, and no bypass occurred during the clr cycle.
- ZERO_R0=1: write 0xFFFF to address 0 → address 0 reads 0 and wr_ack=0. Write 0xFFFF to address 1 → reads 0xFFFF and wr_ack=1.
- Out-of-range (DEPTH=6, AW=3): write 0x7777 to address 7 → no word changes, wr_ack=0, and reading address 6 or 7 returns 0. Back-to-back writes to addresses 0..5 → wr_ack stays high for 6 consecutive cycles.
